control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Moore control FSM that sequences the basic-computer datapath: fetch, decode,
//  indirect resolution and execute. Decodes the datapath IR into one-hot
//  strobes and watches decoding/ex_done/w_mem_ref handshakes.
//  Flags illegal opcodes, handshake timeouts and HLT.
// PARAMETERS
//  CLR_CYCLES   2   cycles o_clr_reg is held after reset release (>=1)
//  TIMEOUT_CYC  16  max cycles in any wait state before timeout
//  CNT_W        16  width of retired-instruction counter
// PORTS
//  clk          in   1      system clock, rising edge
//  i_rst_n      in   1      asynchronous active-low reset
//  i_start      in   1      run request; honoured only in IDLE or HALT
//  i_ir         in   16     datapath IR: [15]=I, [14:12]=opcode, [11:0]=addr/op bits
//  i_decoding   in   1      datapath fetch/decode in progress
//  i_ex_done    in   1      datapath execution complete (level)
//  i_w_mem_ref  in   1      datapath indirect address resolved
//  o_clr_reg    out  1      datapath register clear
//  o_fetch, o_execute, o_is_ind, o_is_dir    out 1 each  phase strobes
//  o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac  out 1  reg-ref ops
//  o_add, o_load, o_store, o_branch, o_isz   out 1 each  mem-ref ops
//  o_busy       out  1      state not in {INIT, IDLE, HALT}
//  o_halted     out  1      state == HALT
//  o_illegal    out  1      sticky: unsupported opcode seen
//  o_timeout    out  1      sticky: handshake timeout
//  o_instr_cnt  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, counters 0, state INIT.
//    Reset asserted mid-operation aborts immediately to INIT; no completion counted.
//  - INIT: o_clr_reg=1 for CLR_CYCLES cycles, then IDLE.
//  - IDLE: i_start=1 at edge N -> FETCH; o_fetch=1 in cycle N+1, exactly 1 cycle.
//  - FETCH -> WAIT_IR. WAIT_IR: leave on first cycle i_decoding=0 after having
//    seen it 1, then DECODE.
//  - DECODE (1 cycle): latch i_ir[15:0] into op register; all strobes from latch.
//    Opcode 001 ADD, 010 LDA, 011 STA, 100 BUN, 110 ISZ: mem-ref.
//      I=1 -> INDIRECT; I=0 -> EXEC.
//    Opcode 111, I=0: reg-ref. Priority IR[0] HLT > IR[11] CLA > IR[10] CLE >
//      IR[9] CMA > IR[8] LDI (load_ac) > IR[7] CIR > IR[6] CIL > IR[5] INC;
//      one strobe only. HLT -> HALT (counted). No bit set = NOP: counted, -> FETCH.
//    Opcode 000, 101, or 111 with I=1: illegal. Set o_illegal, no count, -> FETCH.
//  - INDIRECT: o_is_ind=1 until i_w_mem_ref=1 sampled, then EXEC.
//  - EXEC: o_execute=1. Op strobe held for the whole state. o_is_dir=1 for
//    mem-ref ops. First cycle with i_ex_done=1 -> FETCH, o_instr_cnt+1, strobes
//    drop next cycle. Datapath clears ex_done on fetch; stale ex_done cannot
//    reach EXEC.
//  - Timeout: one counter, cleared on entry to WAIT_IR/INDIRECT/EXEC. Reaching
//    TIMEOUT_CYC cycles in state -> o_timeout=1, all strobes 0, HALT.
//  - HALT: all strobes 0, o_halted=1. i_start -> FETCH; clears o_illegal and
//    o_timeout in the same edge.
//  - i_start outside IDLE/HALT is ignored. Simultaneous done and timeout on the
//    same cycle: done wins.
// TESTING
//  1 Reset release -> o_clr_reg high exactly 2 cycles, then IDLE;
//    all other outputs 0 throughout.
//  2 IR=16'h7800 (CLA), ex_done 2 cycles into EXEC -> o_clr_ac+o_execute high
//    until done, o_instr_cnt=1, o_fetch next.
//  3 IR=16'h9005 (I=1 ADD): w_mem_ref after 3 cycles, then ex_done ->
//    o_is_ind 3 cycles, then o_add+o_is_dir+o_execute, count=1.
//  4 IR=16'h0123 (AND) -> o_illegal=1, no strobe, count unchanged, o_fetch
//    next cycle.
//  5 EXEC with i_ex_done held 0 -> o_timeout=1 after 16 cycles, o_halted=1;
//    i_start clears o_timeout, o_fetch.
//  6 IR=16'h7001 (HLT), then reset asserted mid-EXEC of a later run -> all
//    outputs 0 asynchronously, INIT.

Source files
------------

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Moore control FSM for the basic-computer datapath. Sequences
//               fetch, decode, indirect-address resolution and execute, turns
//               the latched IR into one-hot operation strobes, and watches the
//               decoding / ex_done / w_mem_ref handshakes. Flags illegal
//               opcodes, handshake timeouts and HLT.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 system clock, rising edge
//   i_rst_n             asynchronous active-low reset
//   i_start             run request, honoured only in IDLE or HALT
//   i_ir[15:0]          datapath IR: [15]=I, [14:12]=opcode, [11:0]=addr/op
//   i_decoding          datapath fetch/decode in progress
//   i_ex_done           datapath execution complete (level)
//   i_w_mem_ref         datapath indirect address resolved
//   o_clr_reg           datapath register clear after reset release
//   o_fetch/o_execute/o_is_ind/o_is_dir      phase strobes
//   o_clr_ac..o_inc_ac  register-reference operation strobes
//   o_add..o_isz        memory-reference operation strobes
//   o_busy/o_halted     state summary
//   o_illegal/o_timeout sticky error flags, cleared by a restart from HALT
//   o_instr_cnt         retired-instruction counter (wraps)
// ============================================================================
module control_sequencer #(
  parameter int CLR_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [15:0]      i_ir,
  input  logic             i_decoding,
  input  logic             i_ex_done,
  input  logic             i_w_mem_ref,
  output logic             o_clr_reg,
  output logic             o_fetch,
  output logic             o_execute,
  output logic             o_is_ind,
  output logic             o_is_dir,
  output logic             o_clr_ac,
  output logic             o_clr_e,
  output logic             o_comp_ac,
  output logic             o_load_ac,
  output logic             o_cir_r,
  output logic             o_cir_l,
  output logic             o_inc_ac,
  output logic             o_add,
  output logic             o_load,
  output logic             o_store,
  output logic             o_branch,
  output logic             o_isz,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_illegal,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_instr_cnt
);

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CLR_W-1:0] C_CLR_CYC = CLR_W'(CLR_CYCLES);
  localparam logic [TO_W-1:0]  C_TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_FETCH    = 3'd2,
    S_WAIT_IR  = 3'd3,
    S_DECODE   = 3'd4,
    S_INDIRECT = 3'd5,
    S_EXEC     = 3'd6,
    S_HALT     = 3'd7
  } state_e;

  state_e           state_q;
  logic [CLR_W-1:0] clr_cnt_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             seen_dec_q;
  logic [15:0]      ir_q;
  logic             clr_reg_q, fetch_q, execute_q, is_ind_q, is_dir_q;
  logic [11:0]      strb_q;   // [0]=clr_ac .. [6]=inc_ac, [7]=add .. [11]=isz
  logic             busy_q, halted_q, illegal_q, timeout_q;
  logic [CNT_W-1:0] cnt_q;

  // One-hot operation strobe for the latched instruction; zero for HLT,
  // NOP and illegal encodings.
  function automatic logic [11:0] f_strobe(input logic [15:0] ir);
    logic [11:0] s;
    s = '0;
    case (ir[14:12])
      3'd1:    s[7]  = 1'b1;
      3'd2:    s[8]  = 1'b1;
      3'd3:    s[9]  = 1'b1;
      3'd4:    s[10] = 1'b1;
      3'd6:    s[11] = 1'b1;
      3'd7: begin
        if (!ir[15] && !ir[0]) begin
          if      (ir[11]) s[0] = 1'b1;
          else if (ir[10]) s[1] = 1'b1;
          else if (ir[9])  s[2] = 1'b1;
          else if (ir[8])  s[3] = 1'b1;
          else if (ir[7])  s[4] = 1'b1;
          else if (ir[6])  s[5] = 1'b1;
          else if (ir[5])  s[6] = 1'b1;
        end
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  logic [2:0]  w_op;
  logic        w_mem_ref, w_reg_ref, w_hlt, w_reg_op, w_to_hit;
  logic [11:0] w_op_strb;
  logic        w_unused_ir;

  assign w_op        = ir_q[14:12];
  assign w_mem_ref   = w_op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
  assign w_reg_ref   = (w_op == 3'd7) && !ir_q[15];
  assign w_hlt       = w_reg_ref && ir_q[0];
  assign w_reg_op    = w_reg_ref && !ir_q[0] && (|ir_q[11:5]);
  assign w_to_hit    = (to_cnt_q == C_TO_LAST);
  assign w_op_strb   = f_strobe(ir_q);
  assign w_unused_ir = ^ir_q[4:1];  // reg-ref bits with no assigned operation

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_INIT;
      clr_cnt_q  <= '0;
      to_cnt_q   <= '0;
      seen_dec_q <= 1'b0;
      ir_q       <= '0;
      clr_reg_q  <= 1'b0;
      fetch_q    <= 1'b0;
      execute_q  <= 1'b0;
      is_ind_q   <= 1'b0;
      is_dir_q   <= 1'b0;
      strb_q     <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (clr_cnt_q < C_CLR_CYC) begin
            clr_reg_q <= 1'b1;
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end else begin
            clr_reg_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_IDLE, S_HALT: begin
          if (i_start) begin
            state_q   <= S_FETCH;
            fetch_q   <= 1'b1;
            busy_q    <= 1'b1;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        S_FETCH: begin
          state_q    <= S_WAIT_IR;
          fetch_q    <= 1'b0;
          seen_dec_q <= 1'b0;
          to_cnt_q   <= '0;
        end
        S_WAIT_IR: begin
          // Wait for a full decoding pulse so a late-rising i_decoding is not
          // mistaken for a finished decode.
          if (seen_dec_q && !i_decoding) begin
            state_q <= S_DECODE;
            ir_q    <= i_ir;
          end else if (w_to_hit) begin
            state_q   <= S_HALT;
            timeout_q <= 1'b1;
            halted_q  <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
            if (i_decoding) seen_dec_q <= 1'b1;
          end
        end
        S_DECODE: begin
          if (w_mem_ref && ir_q[15]) begin
            state_q  <= S_INDIRECT;
            is_ind_q <= 1'b1;
            to_cnt_q <= '0;
          end else if (w_mem_ref || w_reg_op) begin
            state_q   <= S_EXEC;
            execute_q <= 1'b1;
            is_dir_q  <= w_mem_ref;
            strb_q    <= w_op_strb;
            to_cnt_q  <= '0;
          end else if (w_hlt) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= cnt_q + 1'b1;
          end else begin
            // NOP retires immediately; illegal encodings retire nothing.
            state_q <= S_FETCH;
            fetch_q <= 1'b1;
            if (w_reg_ref) cnt_q     <= cnt_q + 1'b1;
            else           illegal_q <= 1'b1;
          end
        end
        S_INDIRECT: begin
          if (i_w_mem_ref) begin
            state_q   <= S_EXEC;
            is_ind_q  <= 1'b0;
            execute_q <= 1'b1;
            is_dir_q  <= 1'b1;
            strb_q    <= w_op_strb;
            to_cnt_q  <= '0;
          end else if (w_to_hit) begin
            state_q   <= S_HALT;
            is_ind_q  <= 1'b0;
            timeout_q <= 1'b1;
            halted_q  <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_EXEC: begin
          // Completion is tested before the timeout so a done on the final
          // permitted cycle still retires the instruction.
          if (i_ex_done) begin
            state_q   <= S_FETCH;
            fetch_q   <= 1'b1;
            execute_q <= 1'b0;
            is_dir_q  <= 1'b0;
            strb_q    <= '0;
            cnt_q     <= cnt_q + 1'b1;
          end else if (w_to_hit) begin
            state_q   <= S_HALT;
            execute_q <= 1'b0;
            is_dir_q  <= 1'b0;
            strb_q    <= '0;
            timeout_q <= 1'b1;
            halted_q  <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign o_clr_reg   = clr_reg_q;
  assign o_fetch     = fetch_q;
  assign o_execute   = execute_q;
  assign o_is_ind    = is_ind_q;
  assign o_is_dir    = is_dir_q;
  assign o_clr_ac    = strb_q[0];
  assign o_clr_e     = strb_q[1];
  assign o_comp_ac   = strb_q[2];
  assign o_load_ac   = strb_q[3];
  assign o_cir_r     = strb_q[4];
  assign o_cir_l     = strb_q[5];
  assign o_inc_ac    = strb_q[6];
  assign o_add       = strb_q[7];
  assign o_load      = strb_q[8];
  assign o_store     = strb_q[9];
  assign o_branch    = strb_q[10];
  assign o_isz       = strb_q[11];
  assign o_busy      = busy_q;
  assign o_halted    = halted_q;
  assign o_illegal   = illegal_q;
  assign o_timeout   = timeout_q;
  assign o_instr_cnt = cnt_q;

endmodule
`default_nettype wire
